pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and fetch sequencer that consumes the branch-decision output of the And_Gate
//  (branch & zero, here pc_src) plus the jump control.
//  Holds the PC and requests instructions from instruction memory over a req/ready handshake.
//  Presents each fetched word to the decode/execute datapath for exactly one execute phase,
//  then commits the next PC.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset; must be word aligned
//  ADDR_W      32             PC / address width
// PORTS
//  clk           in   1       system clock, all state updates on rising edge
//  reset         in   1       synchronous, active-high reset
//  imem_ready    in   1       instruction memory: imem_rdata valid this cycle
//  imem_rdata    in   32      fetched instruction word
//  pc_src        in   1       take branch (And_Gate output: branch & zero)
//  jump          in   1       take jump (J/JAL)
//  imm_ext       in   32      sign-extended 16-bit branch offset, in words
//  jump_index    in   26      instr[25:0] jump index
//  stall         in   1       hold current instruction in execute phase
//  imem_req      out  1       fetch request, held until imem_ready
//  imem_addr     out  ADDR_W  fetch address (= pc)
//  pc            out  ADDR_W  current PC
//  pc_plus4      out  ADDR_W  pc + 4 (for JAL link / datapath)
//  instr         out  32      latched instruction
//  instr_valid   out  1       instr is live; datapath executes and commits this cycle
//  misaligned    out  1       sticky: computed next PC had [1:0] != 0; fetch halted
// BEHAVIOUR
//  One clock domain; reset is synchronous and active-high.
//  - Reset: pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, misaligned=0, state=S_BOOT.
//  - FSM states: S_BOOT -> S_FETCH -> S_EXEC -> S_FETCH ...; S_HALT is terminal until reset.
//  - S_BOOT: one cycle, all outputs idle; always -> S_FETCH.
//  - S_FETCH: imem_req=1, imem_addr=pc. On imem_ready:
//    - capture imem_rdata into instr;
//    - go to S_EXEC.
//    - imem_req drops the cycle after ready. Unbounded wait; no timeout.
//  - S_EXEC: instr_valid=1.
//    - If stall=1: hold state, pc and instr unchanged.
//    - Else: pc <= next_pc, then S_FETCH. Minimum 2 cycles per instruction when ready returns in the first fetch cycle.
//  - next_pc priority: jump > pc_src > sequential.
//    - jump: {pc_plus4[31:28], jump_index, 2'b00}
//    - pc_src: pc_plus4 + (imm_ext << 2)
//    - else: pc_plus4
//  - Arithmetic is modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 wraps to 0; no flag.
//  - pc_src and jump are sampled only in S_EXEC with stall=0 and ignored in every other state.
//    jump and pc_src both high: the jump wins.
//  - next_pc[1:0] != 0 can only arise via the ADDR_W parameter or a corrupt imm path.
//    In that case: pc is not updated, misaligned<=1, state -> S_HALT (imem_req=0, instr_valid=0).
//  - imem_ready outside S_FETCH: ignored, no state change.
//  - Reset mid-operation (any state, including a pending fetch) aborts:
//    - next cycle all outputs are at reset values;
//    - a late imem_ready in S_BOOT is dropped.
//  - pc_plus4 is combinational from pc. All other outputs are registered or decoded from state only.
// STRUCTURE
//  - mips_pkg:
//    - state localparams S_BOOT/S_FETCH/S_EXEC/S_HALT (2-bit);
//    - INSTR_BYTES=4;
//    - NPC_SEQ/NPC_BR/NPC_JMP select codes.
//  - Sub-module pc_next_mux (combinational): pc, imm_ext, jump_index, pc_src, jump -> next_pc, npc_sel.
//    Unit-testable on its own.
// TESTING
//  1. Reset, ready returned the cycle after req:
//     - pc=0, imem_addr=0 in FETCH;
//     - instr_valid at cycle 3;
//     - pc=4 after EXEC;
//     - then imem_addr=4.
//  2. pc=0x40, pc_src=1, imm_ext=0xFFFF_FFFE in EXEC -> next pc = 0x44 - 8 = 0x3C.
//  3. pc=0x1000_0000, jump=1, jump_index=0x0000_100, pc_src=1 same cycle -> pc=0x1000_0400 (jump wins).
//  4. stall=1 for 3 EXEC cycles -> pc, instr stable, instr_valid=1 throughout; commit on cycle 4.
//  5. imem_ready delayed 5 cycles -> imem_req held high 5 cycles at a constant address.
//     imem_ready pulsed during EXEC -> ignored.
//  6. pc=0xFFFF_FFFC sequential -> pc=0.
//     Assert reset while in FETCH with ready arriving the same cycle -> pc=RESET_PC, instr=0, state S_BOOT.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the PC/fetch slice: fetch sequencer states and next-PC select codes.
package mips_pkg;

   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_JMP = 2'd2
   } npc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: jump beats branch, branch beats fall-through.
module pc_next_mux
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [31:0]       imm_ext,
   input  logic [25:0]       jump_index,
   input  logic              pc_src,
   input  logic              jump,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] next_pc,
   output npc_sel_t          npc_sel
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] jmp_target;

   // Offsets are in words; everything wraps modulo 2^ADDR_W.
   assign pc_plus4   = pc + STEP;
   assign br_off     = ADDR_W'($signed(imm_ext)) << 2;
   assign br_target  = pc_plus4 + br_off;
   assign jmp_target = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      npc_sel = NPC_SEQ;
      if (jump) begin
         next_pc = jmp_target;
         npc_sel = NPC_JMP;
      end else if (pc_src) begin
         next_pc = br_target;
         npc_sel = NPC_BR;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and fetch sequencer: boot, fetch over req/ready, present one execute phase, commit.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              pc_src,
   input  logic              jump,
   input  logic [31:0]       imm_ext,
   input  logic [25:0]       jump_index,
   input  logic              stall,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic              misaligned
);

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [ADDR_W-1:0] next_pc;
   npc_sel_t          npc_sel;
   logic              pc_load;
   logic              instr_load;
   logic              set_mis;
   logic              npc_bad;

   pc_next_mux #(
      .ADDR_W(ADDR_W)
   ) u_next (
      .pc        (pc),
      .imm_ext   (imm_ext),
      .jump_index(jump_index),
      .pc_src    (pc_src),
      .jump      (jump),
      .pc_plus4  (pc_plus4),
      .next_pc   (next_pc),
      .npc_sel   (npc_sel)
   );

   // Jump targets end in 2'b00 by construction, so only the other paths can misalign.
   assign npc_bad = (npc_sel != NPC_JMP) && (next_pc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_BOOT;
         pc         <= RESET_PC;
         instr      <= '0;
         misaligned <= 1'b0;
      end else begin
         state <= state_next;
         if (pc_load)    pc         <= next_pc;
         if (instr_load) instr      <= imem_rdata;
         if (set_mis)    misaligned <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      pc_load    = 1'b0;
      instr_load = 1'b0;
      set_mis    = 1'b0;
      case (state)
         S_BOOT:  state_next = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               instr_load = 1'b1;
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!stall) begin
               if (npc_bad) begin
                  set_mis    = 1'b1;
                  state_next = S_HALT;
               end else begin
                  pc_load    = 1'b1;
                  state_next = S_FETCH;
               end
            end
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_BOOT;
      endcase
   end

   assign imem_req    = (state == S_FETCH);
   assign imem_addr   = pc;
   assign instr_valid = (state == S_EXEC);

endmodule
